seg7_scan_capture: RTL and testbench



---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_scan_capture_if.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seg7_scan_capture.sv | 125 ++++++++++++
 tb/tb_seg7_scan_capture.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan capture slice.
//   - Segment patterns in gfedcba order (bit0 = a .. bit6 = g).
//   - Special decode codes for blank and unrecognised patterns.
//   - Decode result struct produced by seg7_pattern_decode.
package seg7_pkg;

   localparam logic [6:0] SEG_0       = 7'h3F;
   localparam logic [6:0] SEG_1       = 7'h06;
   localparam logic [6:0] SEG_2       = 7'h5B;
   localparam logic [6:0] SEG_3       = 7'h4F;
   localparam logic [6:0] SEG_4       = 7'h66;
   localparam logic [6:0] SEG_5       = 7'h6D;
   localparam logic [6:0] SEG_6       = 7'h7D;   // tailed six
   localparam logic [6:0] SEG_6_UNTL  = 7'h7C;
   localparam logic [6:0] SEG_7       = 7'h07;
   localparam logic [6:0] SEG_7_TAIL  = 7'h27;
   localparam logic [6:0] SEG_8       = 7'h7F;
   localparam logic [6:0] SEG_9       = 7'h6F;   // tailed nine
   localparam logic [6:0] SEG_9_UNTL  = 7'h67;
   localparam logic [6:0] SEG_BLANK   = 7'h00;

   localparam logic [3:0] CODE_BLANK  = 4'hF;
   localparam logic [3:0] CODE_ERR    = 4'hE;

   typedef struct packed {
      logic [3:0] code;
      logic       blank;
      logic       err;
   } seg7_res_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: frame output bus of seg7_scan_capture.
//   out_valid/out_ready : frame handshake
//   out_bcd             : digit d in bits [4d+3:4d]
//   out_blank/out_err   : per-digit blank / unrecognised flags
//   overrun             : sticky dropped-frame flag
// master = producer (capture block), slave = consumer.
interface seg7_scan_capture_if #(
   parameter int unsigned DIGITS = 4
) ();
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_bcd;
   logic [DIGITS-1:0]     out_blank;
   logic [DIGITS-1:0]     out_err;
   logic                  overrun;

   modport master (
      output out_valid, out_bcd, out_blank, out_err, overrun,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_bcd, out_blank, out_err, overrun,
      output out_ready
   );
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to BCD decoder.
//   pattern : segment pattern, gfedcba
//   result  : code / blank / err
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output seg7_res_t  result
);

   always_comb begin
      result.code  = CODE_ERR;
      result.blank = 1'b0;
      result.err   = 1'b0;
      case (pattern)
         SEG_0:                   result.code = 4'd0;
         SEG_1:                   result.code = 4'd1;
         SEG_2:                   result.code = 4'd2;
         SEG_3:                   result.code = 4'd3;
         SEG_4:                   result.code = 4'd4;
         SEG_5:                   result.code = 4'd5;
         SEG_6, SEG_6_UNTL:       result.code = 4'd6;
         SEG_7, SEG_7_TAIL:       result.code = 4'd7;
         SEG_8:                   result.code = 4'd8;
         SEG_9, SEG_9_UNTL:       result.code = 4'd9;
         SEG_BLANK: begin
            result.code  = CODE_BLANK;
            result.blank = 1'b1;
         end
         default:                 result.err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers BCD digits from a multiplexed 7-segment bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   seg_i      : segment lines a..g, dp (dp ignored)
//   dig_n_i    : active-low digit strobes
//   bus        : frame output (valid/ready, bcd, blank, err, overrun)
// Inputs are registered once; a digit is captured once its (strobe, pattern)
// pair has been identical for STABLE_CYCLES samples. When every digit has
// been captured the frame is handed out; if the consumer still holds the
// previous frame, the new one is dropped and overrun latches.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          seg_i,
   input  logic [DIGITS-1:0]   dig_n_i,
   seg7_scan_capture_if.master bus
);

   localparam int unsigned SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);

   logic [6:0]        seg_s;
   logic [DIGITS-1:0] dig_s;
   logic [DIGITS-1:0] low;
   logic              prev_ok;
   logic [SEL_W-1:0]  prev_sel;
   logic [6:0]        prev_seg;
   logic [7:0]        cnt, cnt_nxt;
   logic              sel_ok;
   logic [SEL_W-1:0]  sel;
   logic              match, capture;
   seg7_res_t         res;
   seg7_res_t         slot     [DIGITS];
   seg7_res_t         slot_nxt [DIGITS];
   logic [DIGITS-1:0] seen, seen_nxt;
   logic              frame_done, accept;

   seg7_pattern_decode u_decode (
      .pattern (seg_s),
      .result  (res)
   );

   // Strobe selection: valid only with exactly one low strobe.
   always_comb begin
      low    = ~dig_s;
      sel_ok = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
      sel    = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (low[i]) sel = SEL_W'(i);
   end

   // Capture fires only on the clock the counter reaches STABLE; the extra
   // term keeps a held pattern from re-capturing once saturated, and still
   // lets STABLE_CYCLES=1 capture on each new pattern.
   always_comb begin
      match = sel_ok && prev_ok && (sel == prev_sel) && (seg_s == prev_seg);
      if (match)
         cnt_nxt = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
      else
         cnt_nxt = sel_ok ? 8'd1 : 8'd0;
      capture = sel_ok && (cnt_nxt == STABLE) && !(match && (cnt == STABLE));
   end

   // Next slot/seen state includes this clock's capture, so a completing
   // frame loads the digit being captured right now.
   always_comb begin
      seen_nxt = seen;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         slot_nxt[i] = slot[i];
         if (capture && (sel == SEL_W'(i))) begin
            slot_nxt[i] = res;
            seen_nxt[i] = 1'b1;
         end
      end
      frame_done = &seen_nxt;
      accept     = bus.out_valid & bus.out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s         <= '0;
         dig_s         <= '1;
         prev_ok       <= 1'b0;
         prev_sel      <= '0;
         prev_seg      <= '0;
         cnt           <= '0;
         seen          <= '0;
         for (int unsigned i = 0; i < DIGITS; i++) slot[i] <= '0;
         bus.out_valid <= 1'b0;
         bus.out_bcd   <= '0;
         bus.out_blank <= '0;
         bus.out_err   <= '0;
         bus.overrun   <= 1'b0;
      end else begin
         seg_s    <= seg_i[6:0];
         dig_s    <= dig_n_i;
         prev_ok  <= sel_ok;
         prev_sel <= sel;
         prev_seg <= seg_s;
         cnt      <= cnt_nxt;
         slot     <= slot_nxt;
         if (frame_done) begin
            seen <= '0;
            if (!bus.out_valid || accept) begin
               bus.out_valid <= 1'b1;
               for (int unsigned i = 0; i < DIGITS; i++) begin
                  bus.out_bcd[4*i +: 4] <= slot_nxt[i].code;
                  bus.out_blank[i]      <= slot_nxt[i].blank;
                  bus.out_err[i]        <= slot_nxt[i].err;
               end
            end else begin
               bus.overrun <= 1'b1;
            end
         end else begin
            seen <= seen_nxt;
            if (accept) bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scoreboard bench for seg7_scan_capture
// (DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_scan_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] seg;
   logic [3:0] dig_n;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
   } exp_t;

   exp_t exp_q[$];

   seg7_scan_capture_if #(.DIGITS(4)) bus ();

   seg7_scan_capture #(
      .DIGITS        (4),
      .STABLE_CYCLES (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg_i   (seg),
      .dig_n_i (dig_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(int d, logic [7:0] s, int n);
      dig_n = ~(4'b0001 << d);
      seg   = s;
      step(n);
   endtask

   task automatic idle(int n);
      dig_n = '1;
      seg   = '0;
      step(n);
   endtask

   task automatic push(logic [15:0] b, logic [3:0] bl, logic [3:0] er);
      exp_t e;
      e.bcd = b; e.blank = bl; e.err = er;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: frame not seen, %0d pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: a negedge with valid & ready means an accept at the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame: got bcd %0h expected no frame", bus.out_bcd);
            end else begin
               e = exp_q.pop_front();
               chk("frame_bcd",   32'(bus.out_bcd),   32'(e.bcd));
               chk("frame_blank", 32'(bus.out_blank), 32'(e.blank));
               chk("frame_err",   32'(bus.out_err),   32'(e.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      dig_n         = '1;
      seg           = '0;
      bus.out_ready = 1'b1;
      step(2);
      @(negedge clk);
      chk("rst_valid",   32'(bus.out_valid), 0);
      chk("rst_bcd",     32'(bus.out_bcd),   0);
      chk("rst_blank",   32'(bus.out_blank), 0);
      chk("rst_err",     32'(bus.out_err),   0);
      chk("rst_overrun", 32'(bus.overrun),   0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1);

      // Basic scan; dp on digit 1 must be ignored.
      push(16'h4321, 4'b0000, 4'b0000);
      drive(0, 8'h06, 5); drive(1, 8'hDB, 5); drive(2, 8'h4F, 5); drive(3, 8'h66, 5);
      idle(2);
      wait_drain("basic");

      // 6D too short to capture, then 7F captures as 8.
      push(16'h3218, 4'b0000, 4'b0000);
      drive(0, 8'h6D, 2); drive(0, 8'h7F, 3);
      drive(1, 8'h06, 5); drive(2, 8'h5B, 5); drive(3, 8'h4F, 5);
      idle(2);
      wait_drain("glitch");

      // Untailed/tailed 6, blank, unknown pattern.
      push(16'hEF66, 4'b0100, 4'b1000);
      drive(0, 8'h7C, 5); drive(1, 8'h7D, 5); drive(2, 8'h00, 5); drive(3, 8'h49, 5);
      idle(2);
      wait_drain("blank_err");

      // Held frame plus dropped second frame.
      bus.out_ready = 1'b0;
      push(16'h8765, 4'b0000, 4'b0000);
      drive(0, 8'h6D, 5); drive(1, 8'h7D, 5); drive(2, 8'h07, 5); drive(3, 8'h7F, 5);
      drive(0, 8'h27, 5); drive(1, 8'h6F, 5); drive(2, 8'h67, 5); drive(3, 8'h5B, 5);
      idle(2);
      @(negedge clk);
      chk("ovr_flag",  32'(bus.overrun),   1);
      chk("ovr_valid", 32'(bus.out_valid), 1);
      chk("ovr_held",  32'(bus.out_bcd),   32'h8765);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      step(1);
      chk("ovr_fall", 32'(bus.out_valid), 0);
      wait_drain("overrun");

      // Two strobes low: never selected, so the later three digits alone
      // cannot complete a frame.
      idle(2);
      dig_n = 4'b1100;
      seg   = 8'h06;
      step(10);
      chk("multi_valid", 32'(bus.out_valid), 0);
      drive(1, 8'h5B, 5); drive(2, 8'h4F, 5); drive(3, 8'h66, 5);
      idle(2);
      @(negedge clk);
      chk("partial_no_frame", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      push(16'h4320, 4'b0000, 4'b0000);
      drive(0, 8'h3F, 5);
      idle(2);
      wait_drain("multi");

      // Reset mid-frame.
      drive(0, 8'h06, 5); drive(1, 8'h06, 5); drive(2, 8'h5B, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bcd",     32'(bus.out_bcd),   0);
      chk("mid_rst_overrun", 32'(bus.overrun),   0);
      chk("mid_rst_valid",   32'(bus.out_valid), 0);
      step(2);
      rst_n = 1'b1;
      drive(2, 8'h4F, 5); drive(3, 8'h66, 5);
      idle(2);
      @(negedge clk);
      chk("post_rst_partial", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      push(16'h4397, 4'b0000, 4'b0000);
      drive(0, 8'h07, 5); drive(1, 8'h6F, 5);
      idle(2);
      wait_drain("post_reset");

      idle(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
